slant_transmitter: RTL and testbench

- Camera-side transmitter for the 4-lane, 6-bit-per-lane slant link consumed by the drone receiver.
- Takes 4-pixel RGB groups from the capture buffer over a valid/ready handshake.
- Frames them with a frame-sync pattern, per-line H-sync symbols and inter-line gaps, then drives four 6-bit lane buses toward the board pins.
- The frame-sync pattern alternates even/odd each frame.

---
 rtl/slant_transmitter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_slant_transmitter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slant_transmitter.sv
// ---------------------------------------------------------------------------
// slant_transmitter
//
// Camera-side transmitter for the 4-lane, 6-bit-per-lane slant link.
// A frame is sent as: frame-sync (4 symbols), then for every line an H-sync
// (2 symbols), the pixel data (H_PIXELS symbols per lane) and an idle gap
// (LINE_GAP symbols). Pixel groups of four 24-bit RGB pixels are pulled from
// the capture buffer with a valid/ready handshake. The link never stalls: a
// group that is not available when needed is replaced by zeros and flagged.
//
// Ports:
//   clk           link clock
//   rstn          asynchronous active-low reset
//   frame_start   single-cycle request to send one frame (ignored while busy)
//   pix_data      4-pixel group, pixel k = pix_data[95-24k -: 24] -> lane k
//   pix_valid     pix_data is valid
//   pix_ready     a group is taken at the end of this cycle
//   lane0_data..lane3_data   registered 6-bit lane symbols
//   busy          a frame is in progress
//   frame_odd     parity of the current/next frame (0 selects FRAME0)
//   frame_done    pulse on the final symbol cycle of a frame
//   underrun      sticky: a group was missing when the link needed it
//   underrun_clr  synchronous clear of underrun (a new underrun wins)
// ---------------------------------------------------------------------------
module slant_transmitter #(
    parameter logic [23:0] FRAME0   = 24'hAA8D55,
    parameter logic [23:0] FRAME1   = 24'hAAB155,
    parameter logic [11:0] HSYNC    = 12'h555,
    parameter int          H_PIXELS = 640,
    parameter int          V_LINES  = 480,
    parameter int          LINE_GAP = 16,
    parameter logic [5:0]  IDLE_SYM = 6'h00
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_start,
    input  logic [95:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [5:0]  lane0_data,
    output logic [5:0]  lane1_data,
    output logic [5:0]  lane2_data,
    output logic [5:0]  lane3_data,
    output logic        busy,
    output logic        frame_odd,
    output logic        frame_done,
    output logic        underrun,
    input  logic        underrun_clr
);

    localparam int GROUPS = H_PIXELS / 4;
    localparam int GRP_W  = (GROUPS > 1)   ? $clog2(GROUPS)   : 1;
    localparam int LINE_W = (V_LINES > 1)  ? $clog2(V_LINES)  : 1;
    localparam int GAP_W  = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(GROUPS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LINE_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FSYNC,
        ST_HSYNC,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t             state, state_n;
    logic [1:0]         sym_cnt, sym_n;
    logic [GRP_W-1:0]   grp_cnt, grp_n;
    logic [LINE_W-1:0]  line_cnt, line_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;

    logic [95:0]        grp_data, grp_next;
    logic [23:0]        lanes_q, lanes_n;
    logic [23:0]        fsync_word;
    logic               frame_odd_q;
    logic               underrun_q;
    logic               ready_i;
    logic               done_i;

    // Picks symbol idx (0 = most significant 6 bits) out of a 24-bit word.
    function automatic logic [5:0] pick_sym(input logic [23:0] word,
                                            input logic [1:0]  idx);
        logic [5:0] s;
        case (idx)
            2'd0:    s = word[23:18];
            2'd1:    s = word[17:12];
            2'd2:    s = word[11:6];
            default: s = word[5:0];
        endcase
        return s;
    endfunction

    // State and counter register. The counters always describe the symbol
    // currently on the lanes, so handshake and status decode straight from
    // them without any input in the path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            sym_cnt  <= '0;
            grp_cnt  <= '0;
            line_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            sym_cnt  <= sym_n;
            grp_cnt  <= grp_n;
            line_cnt <= line_n;
            gap_cnt  <= gap_n;
        end
    end

    // Next-state and counter sequencing. sym_cnt counts the 4 frame-sync
    // symbols, the 2 H-sync symbols and the 4 symbols of each pixel.
    always_comb begin
        state_n = state;
        sym_n   = sym_cnt;
        grp_n   = grp_cnt;
        line_n  = line_cnt;
        gap_n   = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_n = ST_FSYNC;
                    sym_n   = '0;
                    line_n  = '0;
                end
            end
            ST_FSYNC: begin
                sym_n = sym_cnt + 2'd1;
                if (sym_cnt == 2'd3) begin
                    state_n = ST_HSYNC;
                    sym_n   = '0;
                end
            end
            ST_HSYNC: begin
                if (sym_cnt == 2'd0) begin
                    sym_n = 2'd1;
                end else begin
                    state_n = ST_DATA;
                    sym_n   = '0;
                    grp_n   = '0;
                end
            end
            ST_DATA: begin
                sym_n = sym_cnt + 2'd1;
                if (sym_cnt == 2'd3) begin
                    if (grp_cnt == GRP_LAST) begin
                        state_n = ST_GAP;
                        gap_n   = '0;
                        grp_n   = '0;
                    end else begin
                        grp_n = grp_cnt + GRP_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_n = '0;
                    sym_n = '0;
                    if (line_cnt == LINE_LAST) begin
                        state_n = ST_IDLE;
                        line_n  = '0;
                    end else begin
                        state_n = ST_HSYNC;
                        line_n  = line_cnt + LINE_W'(1);
                    end
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Handshake and status decode. A new group is fetched on the cycle just
    // before it is needed: the last H-sync symbol, or the last symbol of a
    // group that is not the last one of the line.
    always_comb begin
        ready_i = 1'b0;
        done_i  = 1'b0;
        if (state == ST_HSYNC && sym_cnt == 2'd1) begin
            ready_i = 1'b1;
        end
        if (state == ST_DATA && sym_cnt == 2'd3 && grp_cnt != GRP_LAST) begin
            ready_i = 1'b1;
        end
        if (state == ST_GAP && gap_cnt == GAP_LAST && line_cnt == LINE_LAST) begin
            done_i = 1'b1;
        end
    end

    // Group to be serialised next. A missing group becomes all zeros so the
    // link timing never stretches.
    always_comb begin
        grp_next = grp_data;
        if (ready_i) begin
            grp_next = pix_valid ? pix_data : '0;
        end
    end

    // Lane symbols for the next cycle, computed from the next state so the
    // lane registers change in the same edge as the state register.
    always_comb begin
        lanes_n    = {4{IDLE_SYM}};
        fsync_word = frame_odd_q ? FRAME1 : FRAME0;
        case (state_n)
            ST_FSYNC: begin
                lanes_n = {4{pick_sym(fsync_word, sym_n)}};
            end
            ST_HSYNC: begin
                lanes_n = {4{(sym_n[0] ? HSYNC[5:0] : HSYNC[11:6])}};
            end
            ST_DATA: begin
                for (int k = 0; k < 4; k++) begin
                    lanes_n[23 - 6*k -: 6] = pick_sym(grp_next[95 - 24*k -: 24], sym_n);
                end
            end
            default: begin
                lanes_n = {4{IDLE_SYM}};
            end
        endcase
    end

    // Datapath and status registers. frame_odd flips on the edge that ends
    // a frame; underrun is sticky and a new event beats a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grp_data    <= '0;
            lanes_q     <= {4{IDLE_SYM}};
            frame_odd_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            grp_data <= grp_next;
            lanes_q  <= lanes_n;
            if (done_i) begin
                frame_odd_q <= ~frame_odd_q;
            end
            if (ready_i && !pix_valid) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign lane0_data = lanes_q[23:18];
    assign lane1_data = lanes_q[17:12];
    assign lane2_data = lanes_q[11:6];
    assign lane3_data = lanes_q[5:0];
    assign pix_ready  = ready_i;
    assign frame_done = done_i;
    assign busy       = (state != ST_IDLE);
    assign frame_odd  = frame_odd_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_slant_transmitter.sv
// ---------------------------------------------------------------------------
// tb_slant_transmitter
//
// Scoreboard bench for slant_transmitter with a small link geometry
// (8 pixels per line, 2 lines, 3 gap symbols -> 30-cycle frames). For every
// frame the reference model expands the frame rules into the full list of
// expected per-cycle lane symbols and status bits; a monitor pops one entry
// for each cycle the transmitter reports busy. A driver feeds the prepared
// pixel groups whenever pix_ready is seen, optionally withholding one.
// ---------------------------------------------------------------------------
module tb_slant_transmitter;

    localparam int HP        = 8;
    localparam int VL        = 2;
    localparam int LG        = 3;
    localparam int GROUPS    = HP / 4;
    localparam int SLOTS     = VL * GROUPS;
    localparam int FRAME_LEN = 4 + VL * (2 + HP + LG);

    localparam logic [23:0] F0 = 24'hAA8D55;
    localparam logic [23:0] F1 = 24'hAAB155;
    localparam logic [11:0] HS = 12'h555;

    typedef struct packed {
        logic [23:0] lanes;
        logic        ready;
        logic        done;
        logic        odd;
        logic        under;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        frame_start = 1'b0;
    logic [95:0] pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        pix_ready;
    logic [5:0]  lane0_data, lane1_data, lane2_data, lane3_data;
    logic        busy, frame_odd, frame_done, underrun;

    exp_t        sb_q[$];
    logic [95:0] slot_data[SLOTS];
    logic        slot_drop[SLOTS];
    int          slot_idx = 0;
    logic        model_odd = 1'b0;
    logic        model_under = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          ready_count = 0;
    int          busy_cycles = 0;

    slant_transmitter #(
        .FRAME0   (F0),
        .FRAME1   (F1),
        .HSYNC    (HS),
        .H_PIXELS (HP),
        .V_LINES  (VL),
        .LINE_GAP (LG),
        .IDLE_SYM (6'h00)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .frame_start  (frame_start),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .lane0_data   (lane0_data),
        .lane1_data   (lane1_data),
        .lane2_data   (lane2_data),
        .lane3_data   (lane3_data),
        .busy         (busy),
        .frame_odd    (frame_odd),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Symbol s (0 = first sent) of a 24-bit word, by plain shifting.
    function automatic logic [5:0] sym_of(input logic [23:0] w, input int s);
        return 6'((w >> (18 - 6 * s)) & 24'h3F);
    endfunction

    // Pixel k of a group (pixel 0 is the most significant 24 bits).
    function automatic logic [23:0] pix_of(input logic [95:0] g, input int k);
        return 24'(g >> (72 - 24 * k));
    endfunction

    // Expands one frame into expected per-cycle entries and pushes them.
    // Returns the underrun value expected once the frame has ended.
    function automatic logic build_frame(input logic clr);
        logic [23:0] lw[FRAME_LEN];
        logic        rdy[FRAME_LEN];
        logic        dn[FRAME_LEN];
        logic [23:0] pat;
        logic [95:0] grp;
        logic        u;
        logic        pend;
        int          i;
        int          nxt;
        exp_t        e;
        pat = model_odd ? F1 : F0;
        i = 0;
        for (int s = 0; s < 4; s++) begin
            lw[i] = {4{sym_of(pat, s)}};
            rdy[i] = 1'b0;
            dn[i] = 1'b0;
            i++;
        end
        for (int l = 0; l < VL; l++) begin
            for (int s = 0; s < 2; s++) begin
                lw[i] = {4{((s == 0) ? HS[11:6] : HS[5:0])}};
                rdy[i] = (s == 1);
                dn[i] = 1'b0;
                i++;
            end
            for (int g = 0; g < GROUPS; g++) begin
                grp = slot_drop[l * GROUPS + g] ? 96'h0 : slot_data[l * GROUPS + g];
                for (int s = 0; s < 4; s++) begin
                    lw[i] = {sym_of(pix_of(grp, 0), s), sym_of(pix_of(grp, 1), s),
                             sym_of(pix_of(grp, 2), s), sym_of(pix_of(grp, 3), s)};
                    rdy[i] = (s == 3) && (g != GROUPS - 1);
                    dn[i] = 1'b0;
                    i++;
                end
            end
            for (int j = 0; j < LG; j++) begin
                lw[i] = 24'h0;
                rdy[i] = 1'b0;
                dn[i] = (l == VL - 1) && (j == LG - 1);
                i++;
            end
        end
        u = model_under;
        pend = 1'b0;
        nxt = 0;
        for (int c = 0; c < FRAME_LEN; c++) begin
            u = pend ? 1'b1 : (clr ? 1'b0 : u);
            pend = 1'b0;
            if (rdy[c]) begin
                pend = slot_drop[nxt];
                nxt++;
            end
            e.lanes = lw[c];
            e.ready = rdy[c];
            e.done  = dn[c];
            e.odd   = model_odd;
            e.under = u;
            sb_q.push_back(e);
        end
        return pend ? 1'b1 : (clr ? 1'b0 : u);
    endfunction

    // Pixel driver: presents the prepared group whenever pix_ready is up,
    // and random (to be ignored) traffic otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (pix_ready && slot_idx < SLOTS) begin
                pix_valid = !slot_drop[slot_idx];
                pix_data  = slot_drop[slot_idx] ? {$urandom, $urandom, $urandom} : slot_data[slot_idx];
                slot_idx++;
            end else begin
                pix_valid = 1'($urandom_range(0, 1));
                pix_data  = {$urandom, $urandom, $urandom};
            end
        end
    end

    // Monitor: one scoreboard entry per busy cycle; idle cycles must show
    // the idle lane state and the settled status flags.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) begin
                busy_cycles++;
                if (pix_ready) ready_count++;
                if (sb_q.size() == 0) begin
                    check_output("unexpected_busy", 64'(busy), 64'(1'b0));
                end else begin
                    e = sb_q.pop_front();
                    check_output("frame_cycle",
                                 64'({lane0_data, lane1_data, lane2_data, lane3_data,
                                      pix_ready, frame_done, frame_odd, underrun}),
                                 64'(e));
                end
            end else begin
                check_output("idle_state",
                             64'({lane0_data, lane1_data, lane2_data, lane3_data,
                                  pix_ready, frame_done, frame_odd, underrun}),
                             64'({24'h0, 1'b0, 1'b0, model_odd, model_under}));
            end
        end
    end

    task automatic fill_slots(input int drop_mode);
        for (int s = 0; s < SLOTS; s++) begin
            slot_data[s] = {$urandom, $urandom, $urandom};
            case (drop_mode)
                0:       slot_drop[s] = 1'b0;
                1:       slot_drop[s] = ($urandom_range(0, 3) == 0);
                default: slot_drop[s] = (s == drop_mode - 2);
            endcase
        end
    endtask

    // Sends one frame. frame_start is pulsed at random while the frame is
    // in flight (including the frame_done cycle); reset_at >= 0 pulls rstn
    // that many cycles into the frame.
    task automatic apply_stimulus(input logic clr, input int reset_at);
        logic fin;
        int   k;
        @(posedge clk); #1;
        slot_idx = 0;
        ready_count = 0;
        busy_cycles = 0;
        underrun_clr = clr;
        fin = build_frame(clr);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        k = 0;
        while (sb_q.size() != 0 && k < FRAME_LEN + 20) begin
            if (k == reset_at) begin
                rstn = 1'b0;
                frame_start = 1'b0;
                underrun_clr = 1'b0;
                sb_q.delete();
                model_odd = 1'b0;
                model_under = 1'b0;
                #1;
                check_output("reset_lanes", 64'({lane0_data, lane1_data, lane2_data, lane3_data}), 64'h0);
                check_output("reset_busy", 64'(busy), 64'h0);
                check_output("reset_odd", 64'(frame_odd), 64'h0);
                check_output("reset_ready", 64'(pix_ready), 64'h0);
                @(negedge clk);
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            frame_start = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            k++;
        end
        frame_start = 1'b0;
        underrun_clr = 1'b0;
        if (sb_q.size() != 0) begin
            check_output("frame_timeout", 64'(sb_q.size()), 64'h0);
            sb_q.delete();
        end else begin
            model_odd = ~model_odd;
            model_under = fin;
            check_output("ready_pulses", 64'(ready_count), 64'(SLOTS));
            check_output("frame_cycles", 64'(busy_cycles), 64'(FRAME_LEN));
        end
    endtask

    task automatic clear_underrun();
        @(posedge clk); #1;
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        model_under = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_output("rst_lanes", 64'({lane0_data, lane1_data, lane2_data, lane3_data}), 64'h0);
        check_output("rst_flags", 64'({pix_ready, busy, frame_done, underrun, frame_odd}), 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Known groups, first frame uses FRAME0.
        slot_data[0] = 96'h111111_222222_333333_444444;
        slot_data[1] = 96'h555555_666666_777777_888888;
        slot_data[2] = 96'h999999_AAAAAA_BBBBBB_CCCCCC;
        slot_data[3] = 96'hDDDDDD_EEEEEE_FFFFFF_123456;
        for (int s = 0; s < SLOTS; s++) slot_drop[s] = 1'b0;
        apply_stimulus(1'b0, -1);

        // Second frame uses FRAME1.
        fill_slots(0);
        apply_stimulus(1'b0, -1);

        // Second group of line 0 withheld, then cleared while idle.
        fill_slots(3);
        apply_stimulus(1'b0, -1);
        repeat (3) @(posedge clk);
        clear_underrun();

        // Clear held through a frame with a missing group: set wins.
        fill_slots(2);
        apply_stimulus(1'b1, -1);

        for (int f = 0; f < 6; f++) begin
            fill_slots(1);
            apply_stimulus(1'($urandom_range(0, 3) == 0), -1);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        // Reset in the middle of line 0 data, then a clean FRAME0 frame.
        fill_slots(0);
        apply_stimulus(1'b0, 10);
        repeat (2) @(posedge clk);
        fill_slots(0);
        apply_stimulus(1'b0, -1);

        repeat (4) @(posedge clk);
        check_output("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
